// File: rtl/alu_result_buffer.sv
// Result FIFO between an ALU and its consumer. Each entry stores the result with
// its {N,Z,P,OVF} flags; the last accepted result is fed back as the accumulator.
module alu_result_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           R,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [3:0]                 out_flags,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           acc,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [3:0]       flags;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             ovf_q;
   logic             ovf_next;
   logic [WIDTH-1:0] acc_q;
   logic             push;
   logic             pop;
   logic             drop;
   entry_t           new_entry;

   assign in_ready  = (count_q < FULL_COUNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign drop      = in_valid && !in_ready;

   // The OVF bit stored with an entry reflects the overflow register after this
   // cycle's set/clear, so a clear in the push cycle yields OVF=0 in that entry.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      ovf_next = ovf_q;
      if (drop)
         ovf_next = 1'b1;
      else if (clr_ovf)
         ovf_next = 1'b0;

      new_entry.data  = R;
      new_entry.flags = {R[WIDTH-1], (R == '0), ^R, ovf_next};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         ovf_q <= ovf_next;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            acc_q  <= R;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: entry storage is deliberately left out of reset; out_valid masks stale contents.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= new_entry;
   end

   assign out_data  = mem[rd_ptr].data;
   assign out_flags = mem[rd_ptr].flags;
   assign acc       = acc_q;
   assign count     = count_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus random traffic,
// compared against a queue-based reference model of the buffer.
module tb_alu_result_buffer;

   localparam int W = 8;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  R;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_data;
   logic [3:0]    out_flags;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  acc;
   logic [$clog2(D):0] count;
   logic          clr_ovf;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: queue entries are {data, flags}.
   logic [W+3:0] m_q[$];
   logic         m_ovf;
   logic [W-1:0] m_acc;

   alu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .R(R), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid),
      .out_ready(out_ready), .acc(acc), .count(count), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] flags_of(input logic [W-1:0] r, input logic o);
      return {r[W-1], r == 0, ($countones(r) % 2) == 1, o};
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() < D));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
      check({tag, ".count"},     32'(count),     32'(m_q.size()));
      check({tag, ".acc"},       32'(acc),       32'(m_acc));
      if (m_q.size() > 0) begin
         check({tag, ".out_data"},  32'(out_data),  32'(m_q[0][W+3:4]));
         check({tag, ".out_flags"}, 32'(out_flags), 32'(m_q[0][3:0]));
      end
   endtask

   // One clock: check current outputs, drive inputs, advance DUT and model together.
   task automatic cycle(input string tag, input logic v, input logic [W-1:0] r,
                        input logic ordy, input logic clr);
      bit full, push, pop;
      logic ovf_n;
      check_state(tag);
      in_valid = v; R = r; out_ready = ordy; clr_ovf = clr;
      full  = (m_q.size() == D);
      push  = v && !full;
      pop   = (m_q.size() > 0) && ordy;
      ovf_n = (v && full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      @(posedge clk);
      #1;
      m_ovf = ovf_n;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         m_q.push_back({r, flags_of(r, ovf_n)});
         m_acc = r;
      end
      in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 1'b0;
      m_acc = '0;
   endtask

   initial begin
      rst_n = 1'b0; R = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      model_reset();
      #12;
      check("rst.count", 32'(count), 0);
      check("rst.out_valid", 32'(out_valid), 0);
      check("rst.in_ready", 32'(in_ready), 1);
      check("rst.acc", 32'(acc), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero result at the head
      cycle("push00", 1, 8'h00, 0, 0);
      check("push00.out_flags_const", 32'(out_flags), 32'h4);
      check("push00.count_const", 32'(count), 1);
      cycle("drain00", 0, 0, 1, 0);

      // Fill with four results, then drain in order
      cycle("fill0", 1, 8'h80, 0, 0);
      cycle("fill1", 1, 8'h07, 0, 0);
      cycle("fill2", 1, 8'hFF, 0, 0);
      cycle("fill3", 1, 8'h01, 0, 0);
      check("full.in_ready_const", 32'(in_ready), 0);
      check("full.count_const", 32'(count), 4);
      check("full.head_flags_const", 32'(out_flags), 32'hA);
      for (int i = 0; i < 4; i++) cycle("drain4", 0, 0, 1, 0);

      // Overflow drop, sticky OVF, clear
      for (int i = 0; i < 4; i++) cycle("refill", 1, W'(8'h10 + i), 0, 0);
      cycle("drop55", 1, 8'h55, 0, 0);
      check("drop.count_const", 32'(count), 4);
      check("drop.acc_const", 32'(acc), 32'h13);
      cycle("pop1", 0, 0, 1, 0);
      cycle("push_ovf", 1, 8'h20, 0, 0);
      cycle("clr", 0, 0, 0, 1);
      cycle("push_clean", 1, 8'h21, 0, 0);
      for (int i = 0; i < 4; i++) cycle("drain_ovf", 0, 0, 1, 0);
      cycle("after_ovf", 0, 0, 1, 0);

      // Steady state push+pop at count 2 across pointer wrap
      cycle("pre2a", 1, 8'h40, 0, 0);
      cycle("pre2b", 1, 8'h41, 0, 0);
      for (int i = 0; i < 10; i++) cycle("stream", 1, W'(8'h42 + i), 1, 0);
      check("stream.count_const", 32'(count), 2);
      check("stream.head_const", 32'(out_data), 32'h4A);

      // Full with simultaneous push and pop: pop only
      cycle("fill_to4a", 1, 8'h60, 0, 0);
      cycle("fill_to4b", 1, 8'h61, 0, 0);
      cycle("full_pp", 1, 8'h62, 1, 0);
      check("full_pp.count_const", 32'(count), 3);
      check("full_pp.in_ready_const", 32'(in_ready), 1);

      // Asynchronous reset mid-cycle with three entries stored
      #2 rst_n = 1'b0;
      #1;
      check("arst.out_valid", 32'(out_valid), 0);
      check("arst.count", 32'(count), 0);
      check("arst.acc", 32'(acc), 0);
      check("arst.in_ready", 32'(in_ready), 1);
      #1 rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      cycle("push3c", 1, 8'h3C, 0, 0);
      check("push3c.data_const", 32'(out_data), 32'h3C);
      check("push3c.flags_const", 32'(out_flags), 32'h0);
      cycle("drain3c", 0, 0, 1, 0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cycle("rand", $urandom_range(0, 3) != 0, W'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
      check_state("final");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter WIDTH, default 8, data width of the ALU result R.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 R  input  WIDTH  combinational result from the ALU.
REQ-006 in_valid  input  1  R is valid this cycle.
REQ-007 in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 out_data  output  WIDTH  result at the FIFO head.
REQ-009 out_flags  output  4  flags at the FIFO head, {N,Z,P,OVF}.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-012 acc  output  WIDTH  last accepted result, fed back to the ALU A operand.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 clr_ovf  input  1  synchronous clear of the sticky overflow flag.

Function
REQ-015 A push occurs when in_valid && in_ready; a pop occurs when out_valid && out_ready.
REQ-016 in_ready is 1 iff count < DEPTH; there is no pass-through when full, even with a simultaneous pop.
REQ-017 out_valid is 1 iff count > 0; out_data and out_flags come straight from the head entry register, with no combinational path from R.
REQ-018 Push latency: data pushed at edge k is visible at the head (if the FIFO was empty) with out_valid=1 after edge k.
REQ-019 Flags are computed from R at push time and stored with the entry: N=R[WIDTH-1]; Z=(R==0); P=XOR-reduction of R (1 = odd number of ones).
REQ-020 The stored OVF bit is the value of the sticky overflow register at push time, after any update made in the same cycle.
REQ-021 The sticky overflow register sets when in_valid=1 while in_ready=0; the dropped R is discarded and no state other than overflow changes.
REQ-022 clr_ovf=1 clears the overflow register; if a set condition occurs in the same cycle, set wins.
REQ-023 Read and write pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-024 count is held as a separate register: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-025 Simultaneous push and pop while empty is impossible (out_valid=0); while full, only the pop occurs (REQ-016).
REQ-026 acc loads R on every push and holds otherwise; pops do not affect acc.
REQ-027 Storage is plain registers; no RAM inference is required, and there is no read latency beyond REQ-018.

Reset
REQ-028 rst_n=0 immediately forces pointers=0, count=0, overflow=0, acc=0, out_valid=0 and in_ready=1, without waiting for a clock edge.
REQ-029 Entry storage contents need not be reset; out_data and out_flags are don't-care while out_valid=0.
REQ-030 Reset asserted mid-transfer discards all entries; the first push after release lands at entry 0.
REQ-031 Release of rst_n is assumed synchronous to clk by the surrounding design; the block has no internal synchronizer.

Verification
REQ-032 Reset, then push R=8'h00 with out_ready=0 -> next cycle out_valid=1, out_data=8'h00, out_flags=4'b0100, acc=8'h00, count=1.
REQ-033 Push 8'h80, 8'h07, 8'hFF, 8'h01 back-to-back with out_ready=0 -> in_ready=0 after 4th edge, count=4; pops return data in order with flags 1_0_1_0, 0_0_1_0, 1_0_0_0, 0_0_1_0.
REQ-034 Full FIFO, in_valid=1 with R=8'h55 -> entry dropped, count stays 4, acc unchanged; the next pushed entry after space frees carries OVF=1; clr_ovf=1 then clears it, and the following push carries OVF=0.
REQ-035 count=2, in_valid=1 and out_ready=1 held for 10 cycles with an incrementing R -> count stays 2, outputs ordered, pointers wrap with no loss or duplication.
REQ-036 Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> only the pop occurs; count=3, and in_ready=1 next cycle.
REQ-037 rst_n pulsed low between edges with count=3 -> out_valid=0, count=0, acc=0 immediately; after release, push 8'h3C appears at the head with out_flags=4'b0000.
